// File: rtl/regfile_port_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// regfile_port_ctrl_pkg
// Shared constants and the issue FSM state type for the register file
// requester port (8 x 10-bit file).
// -----------------------------------------------------------------------------
package regfile_port_ctrl_pkg;

  localparam int DATA_W = 10;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// One pending bit per register. A bit is set when an instruction that writes
// that register issues, and cleared when its writeback reaches the file.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   set_en / set_idx    mark a register as pending
//   clr_en / clr_idx    writeback committing to a register
//   chk_*               fields of the instruction waiting to issue
//   hazard              instruction reads or writes a pending register
//   clr_hit             register being cleared was actually pending
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_idx,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_idx,
  input  logic [ADDR_W-1:0] chk_rs1,
  input  logic [ADDR_W-1:0] chk_rs2,
  input  logic [ADDR_W-1:0] chk_rd,
  input  logic              chk_use_rs2,
  input  logic              chk_wr,
  output logic              hazard,
  output logic              clr_hit
);

  logic [NREGS-1:0] r_pend;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
    end else begin
      if (clr_en) r_pend[clr_idx] <= 1'b0;
      // Placed after the clear so a coinciding set on the same bit wins.
      if (set_en) r_pend[set_idx] <= 1'b1;
    end
  end

  // Evaluated on the registered bits only; a same-cycle clear does not unblock.
  assign hazard  = r_pend[chk_rs1]
                 | (chk_use_rs2 & r_pend[chk_rs2])
                 | (chk_wr      & r_pend[chk_rd]);
  assign clr_hit = r_pend[clr_idx];

endmodule

// File: rtl/regfile_port_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_port_ctrl
// Requester side of the register file port. Accepts decoded instructions,
// reads both operands from the file in one READ cycle, holds them for the
// execute stage, and registers execute-stage writebacks onto the write port.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   issue_*                         decoded instruction, valid/ready handshake
//   rs1, rs2, rf, rd1, rd2          file read selects, enable, read data
//   ws, wd, wf                      file write select, data, enable (1 pulse)
//   ex_*                            operands to execute, valid/ready handshake
//   wb_valid, wb_ws, wb_data        writeback request from execute
//   err_wb                          sticky: writeback to a non-pending register
// -----------------------------------------------------------------------------
module regfile_port_ctrl #(
  parameter int DATA_W = regfile_port_ctrl_pkg::DATA_W,
  parameter int ADDR_W = regfile_port_ctrl_pkg::ADDR_W,
  parameter int NREGS  = regfile_port_ctrl_pkg::NREGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] issue_rs1,
  input  logic [ADDR_W-1:0] issue_rs2,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              issue_use_rs2,
  input  logic              issue_wr,
  output logic [ADDR_W-1:0] rs1,
  output logic [ADDR_W-1:0] rs2,
  output logic              rf,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  output logic [ADDR_W-1:0] ws,
  output logic [DATA_W-1:0] wd,
  output logic              wf,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [ADDR_W-1:0] ex_rd,
  output logic              ex_wr,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_ws,
  input  logic [DATA_W-1:0] wb_data,
  output logic              err_wb
);

  import regfile_port_ctrl_pkg::state_t;
  import regfile_port_ctrl_pkg::IDLE;
  import regfile_port_ctrl_pkg::READ;
  import regfile_port_ctrl_pkg::HOLD;

  state_t            r_state, w_next_state;
  logic              w_hazard, w_clr_hit, w_accept, w_idle_ready, w_rf;
  logic [ADDR_W-1:0] r_rs1, r_rs2, r_rd, r_ws, r_ex_rd;
  logic              r_use_rs2, r_wr, r_wf, r_err, r_ex_valid, r_ex_wr;
  logic [DATA_W-1:0] r_wd, r_ex_a, r_ex_b;

  regfile_scoreboard #(.ADDR_W(ADDR_W), .NREGS(NREGS)) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .set_en      (w_accept & issue_wr),
    .set_idx     (issue_rd),
    .clr_en      (r_wf),
    .clr_idx     (r_ws),
    .chk_rs1     (issue_rs1),
    .chk_rs2     (issue_rs2),
    .chk_rd      (issue_rd),
    .chk_use_rs2 (issue_use_rs2),
    .chk_wr      (issue_wr),
    .hazard      (w_hazard),
    .clr_hit     (w_clr_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_idle_ready = 1'b0;
    w_accept     = 1'b0;
    w_rf         = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_idle_ready = ~w_hazard;
        if (issue_valid && !w_hazard) begin
          w_accept     = 1'b1;
          w_next_state = READ;
        end
      end
      READ: begin
        w_rf         = 1'b1;
        w_next_state = HOLD;
      end
      HOLD: begin
        if (ex_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_use_rs2  <= 1'b0;
      r_wr       <= 1'b0;
      r_ex_valid <= 1'b0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
      r_ex_rd    <= '0;
      r_ex_wr    <= 1'b0;
      r_ws       <= '0;
      r_wd       <= '0;
      r_wf       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rs1     <= issue_rs1;
        r_rs2     <= issue_rs2;
        r_rd      <= issue_rd;
        r_use_rs2 <= issue_use_rs2;
        r_wr      <= issue_wr;
      end
      if (r_state == READ) begin
        r_ex_a     <= rd1;
        r_ex_b     <= r_use_rs2 ? rd2 : '0;
        r_ex_rd    <= r_rd;
        r_ex_wr    <= r_wr;
        r_ex_valid <= 1'b1;
      end else if (r_state == HOLD && ex_ready) begin
        r_ex_valid <= 1'b0;
      end
      r_wf <= wb_valid;
      if (wb_valid) begin
        r_ws <= wb_ws;
        r_wd <= wb_data;
      end
      // Judged when the write commits, against the same bit it clears.
      if (r_wf && !w_clr_hit) r_err <= 1'b1;
    end
  end

  assign issue_ready = w_idle_ready & ~reset;
  assign rs1         = r_rs1;
  assign rs2         = r_rs2;
  assign rf          = w_rf;
  assign ws          = r_ws;
  assign wd          = r_wd;
  assign wf          = r_wf;
  assign ex_valid    = r_ex_valid;
  assign ex_a        = r_ex_a;
  assign ex_b        = r_ex_b;
  assign ex_rd       = r_ex_rd;
  assign ex_wr       = r_ex_wr;
  assign err_wb      = r_err;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regfile_port_ctrl
// Bench for regfile_port_ctrl. Acts as the register file itself and keeps a
// plain model of the file contents and of which registers await writeback.
// -----------------------------------------------------------------------------
module tb_regfile_port_ctrl;
  import regfile_port_ctrl_pkg::*;

  typedef struct packed {
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] rd;
    logic       use_rs2;
    logic       wr;
  } op_t;

  typedef struct packed {
    op_t  op;
    logic exp_ready;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              issue_valid, issue_ready, issue_use_rs2, issue_wr;
  logic [ADDR_W-1:0] issue_rs1, issue_rs2, issue_rd;
  logic [ADDR_W-1:0] rs1, rs2, ws, ex_rd, wb_ws;
  logic              rf, wf, ex_valid, ex_ready, ex_wr, wb_valid, err_wb;
  logic [DATA_W-1:0] rd1, rd2, wd, ex_a, ex_b, wb_data;

  logic [DATA_W-1:0] mem      [NREGS];
  logic [DATA_W-1:0] init_val [NREGS];
  logic [DATA_W-1:0] ref_mem  [NREGS];
  bit                pend_m   [NREGS];
  bit                err_m;
  op_t               cur;
  int                checks = 0;
  int                errors = 0;
  vec_t              vecs [10];

  always #5 clk = ~clk;

  regfile_port_ctrl dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_use_rs2(issue_use_rs2), .issue_wr(issue_wr),
    .rs1(rs1), .rs2(rs2), .rf(rf), .rd1(rd1), .rd2(rd2),
    .ws(ws), .wd(wd), .wf(wf),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_a(ex_a), .ex_b(ex_b),
    .ex_rd(ex_rd), .ex_wr(ex_wr),
    .wb_valid(wb_valid), .wb_ws(wb_ws), .wb_data(wb_data),
    .err_wb(err_wb)
  );

  // Register file stand-in: reloads known contents on reset, reads are
  // combinational and return a marker value when not enabled.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= init_val[i];
    end else if (wf) begin
      mem[ws] <= wd;
    end
  end
  assign rd1 = rf ? mem[rs1] : 10'h2AA;
  assign rd2 = rf ? mem[rs2] : 10'h2AA;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit hz(input op_t o);
    return pend_m[o.rs1] || (o.use_rs2 && pend_m[o.rs2]) || (o.wr && pend_m[o.rd]);
  endfunction

  function automatic op_t mk(input int a, input int b, input int d, input bit u, input bit w);
    logic [31:0] t;
    op_t o;
    t = a; o.rs1 = t[2:0];
    t = b; o.rs2 = t[2:0];
    t = d; o.rd  = t[2:0];
    o.use_rs2 = u;
    o.wr      = w;
    return o;
  endfunction

  function automatic op_t rand_op();
    logic [31:0] r;
    op_t o;
    r = $urandom;
    o.rs1 = r[2:0]; o.rs2 = r[5:3]; o.rd = r[8:6];
    o.use_rs2 = r[9]; o.wr = r[10] | r[11];
    return o;
  endfunction

  task automatic drive_op(input op_t o, input logic v);
    issue_rs1 = o.rs1; issue_rs2 = o.rs2; issue_rd = o.rd;
    issue_use_rs2 = o.use_rs2; issue_wr = o.wr; issue_valid = v;
    cur = o;
  endtask

  task automatic model_reset();
    err_m = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      pend_m[i]  = 1'b0;
      ref_mem[i] = init_val[i];
    end
  endtask

  // Writeback issued while the controller is idle: one wf pulse, pend cleared
  // after the wf cycle, err raised if the register was not pending.
  task automatic do_wb(input logic [2:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    wb_valid = 1'b1; wb_ws = a; wb_data = d;
    @(negedge clk);
    wb_valid = 1'b0;
    #1;
    check("wb_write", {wf, ws, wd}, {1'b1, a, d});
    check("wb_ready_during_wf", issue_ready, !hz(cur));
    if (!pend_m[a]) err_m = 1'b1;
    pend_m[a]  = 1'b0;
    ref_mem[a] = d;
    @(negedge clk);
    #1;
    check("wb_pulse_end", wf, 1'b0);
    check("wb_err", err_wb, err_m);
    check("wb_ready_after", issue_ready, !hz(cur));
  endtask

  // Full instruction: clear hazards with writebacks, issue, check READ and
  // operand capture, hold 'hold' extra cycles, then release to execute.
  task automatic issue_op(input op_t o, input int hold);
    logic [24:0] exp;
    logic [2:0]  a;
    logic [31:0] r;
    for (int g = 0; g < 4 && hz(o); g++) begin
      if (pend_m[o.rs1])                   a = o.rs1;
      else if (o.use_rs2 && pend_m[o.rs2]) a = o.rs2;
      else                                 a = o.rd;
      r = $urandom;
      do_wb(a, r[DATA_W-1:0]);
    end
    @(negedge clk);
    drive_op(o, 1'b1);
    #1 check("issue_ready", issue_ready, 1'b1);
    @(negedge clk);
    issue_valid = 1'b0;
    #1 check("read_cycle", {rf, rs1, rs2}, {1'b1, o.rs1, o.rs2});
    if (o.wr) pend_m[o.rd] = 1'b1;
    exp = {1'b1, ref_mem[o.rs1], (o.use_rs2 ? ref_mem[o.rs2] : 10'd0), o.rd, o.wr};
    @(negedge clk);
    #1 check("ex_capture", {rf, ex_valid, ex_a, ex_b, ex_rd, ex_wr}, {1'b0, exp});
    check("ready_busy", issue_ready, 1'b0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1 check("ex_hold", {ex_valid, ex_a, ex_b, ex_rd, ex_wr}, exp);
      check("ready_hold", issue_ready, 1'b0);
    end
    ex_ready = 1'b1;
    @(negedge clk);
    ex_ready = 1'b0;
    #1 check("ex_release", ex_valid, 1'b0);
    check("idle_ready", issue_ready, !hz(o));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    op_t o;
    reset = 1'b1; issue_valid = 1'b0; ex_ready = 1'b0; wb_valid = 1'b0;
    wb_ws = '0; wb_data = '0;
    drive_op(mk(0, 0, 0, 0, 0), 1'b0);
    for (int i = 0; i < NREGS; i++) begin
      r = $urandom;
      init_val[i] = r[DATA_W-1:0];
    end
    init_val[1] = 10'd2;
    init_val[2] = 10'd4;

    // Hazard table, applied with R3 and R5 pending.
    vecs[0] = '{mk(3, 0, 0, 0, 0), 1'b0};
    vecs[1] = '{mk(1, 3, 0, 1, 0), 1'b0};
    vecs[2] = '{mk(1, 3, 0, 0, 0), 1'b1};
    vecs[3] = '{mk(0, 0, 5, 0, 1), 1'b0};
    vecs[4] = '{mk(0, 0, 5, 0, 0), 1'b1};
    vecs[5] = '{mk(0, 0, 3, 0, 1), 1'b0};
    vecs[6] = '{mk(5, 0, 0, 0, 0), 1'b0};
    vecs[7] = '{mk(7, 6, 4, 1, 1), 1'b1};
    vecs[8] = '{mk(2, 5, 0, 1, 0), 1'b0};
    vecs[9] = '{mk(6, 6, 6, 1, 1), 1'b1};

    // Reset and reset values.
    repeat (2) @(negedge clk);
    #1 check("ready_in_reset", issue_ready, 1'b0);
    reset = 1'b0;
    model_reset();
    #1;
    check("reset_outputs",
          {rf, wf, ex_valid, ex_a, ex_b, ex_rd, ex_wr, rs1, rs2, ws, wd, err_wb}, 64'd0);
    check("reset_ready", issue_ready, 1'b1);

    // First instruction with a 4-cycle execute stall, then one pending R5.
    issue_op(mk(1, 2, 3, 1, 1), 4);
    issue_op(mk(0, 0, 5, 0, 1), 0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_op(vecs[i].op, 1'b0);
      #1 check($sformatf("hazard_vec%0d", i), issue_ready, vecs[i].exp_ready);
    end

    // RAW: rs1=R3 waits for the writeback, released the cycle after wf.
    @(negedge clk);
    drive_op(mk(3, 0, 0, 0, 0), 1'b1);
    wb_valid = 1'b1; wb_ws = 3'd3; wb_data = 10'h1A5;
    #1 check("raw_stall", issue_ready, 1'b0);
    @(negedge clk);
    wb_valid = 1'b0;
    #1 check("raw_wf", {wf, ws, wd}, {1'b1, 3'd3, 10'h1A5});
    check("raw_stall_wf", issue_ready, 1'b0);
    pend_m[3] = 1'b0; ref_mem[3] = 10'h1A5;
    @(negedge clk);
    #1 check("raw_release", issue_ready, 1'b1);
    @(negedge clk);
    issue_valid = 1'b0;
    #1 check("raw_read", rf, 1'b1);
    @(negedge clk);
    #1 check("raw_ex_a", {ex_valid, ex_a}, {1'b1, 10'h1A5});
    ex_ready = 1'b1;
    @(negedge clk);
    ex_ready = 1'b0;
    #1 check("raw_done", ex_valid, 1'b0);

    // WAW: rd=R5 while R5 pending stalls until its writeback commits.
    @(negedge clk);
    drive_op(mk(0, 0, 5, 0, 1), 1'b0);
    #1 check("waw_stall", issue_ready, 1'b0);
    issue_op(mk(0, 0, 5, 0, 1), 1);

    // Writeback to non-pending R6: still writes, sticky error.
    do_wb(3'd6, 10'h0F3);
    repeat (3) @(negedge clk);
    #1 check("err_sticky", err_wb, 1'b1);
    issue_op(mk(6, 6, 0, 1, 0), 0);

    // Reset while holding operands, with pend R4 and a writeback in flight.
    @(negedge clk);
    drive_op(mk(1, 2, 4, 0, 1), 1'b1);
    @(negedge clk);
    issue_valid = 1'b0;
    @(negedge clk);
    #1 check("no_rs2_exb", {ex_valid, ex_a, ex_b}, {1'b1, ref_mem[1], 10'd0});
    reset = 1'b1; wb_valid = 1'b1; wb_ws = 3'd4; wb_data = 10'h155;
    @(negedge clk);
    reset = 1'b0; wb_valid = 1'b0;
    model_reset();
    drive_op(mk(5, 0, 4, 0, 1), 1'b0);
    #1 check("rst_hold_state", {wf, ex_valid, err_wb}, 3'd0);
    check("rst_pend_cleared", issue_ready, 1'b1);
    @(negedge clk);
    #1 check("rst_no_wf", wf, 1'b0);

    // Random instruction stream against the model.
    for (int k = 0; k < 60; k++) begin
      o = rand_op();
      r = $urandom;
      if (r[1:0] == 2'd0) begin
        for (int i = 0; i < NREGS; i++) begin
          if (pend_m[i]) begin
            do_wb(i[2:0], r[DATA_W+1:2]);
            break;
          end
        end
      end
      issue_op(o, int'(r[4:3] % 3));
    end
    check("final_err", err_wb, err_m);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
